// File: rtl/bk_pkg.sv
// Shared definitions for the sequential wide adder: slice width and FSM state encoding.
package bk_pkg;

   localparam int BK_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } bk_state_e;

endpackage

// File: rtl/brent_kung_adder.sv
// 32-bit Brent-Kung parallel-prefix adder; purely combinational, zero latency, no backpressure.
module brent_kung_adder
   import bk_pkg::*;
(
   input  logic [BK_WORD_W-1:0] a,
   input  logic [BK_WORD_W-1:0] b,
   input  logic                 cin,
   output logic [BK_WORD_W-1:0] sum,
   output logic                 cout
);

   localparam int LG = $clog2(BK_WORD_W);

   logic [BK_WORD_W-1:0] p;
   logic [BK_WORD_W-1:0] gg;
   logic [BK_WORD_W-1:0] pp;

   // cin is folded into bit 0 generate so gg[i] becomes the carry out of bit i
   always_comb begin
      p     = a ^ b;
      gg    = a & b;
      gg[0] = gg[0] | (p[0] & cin);
      pp    = p;
      for (int d = 0; d < LG; d++) begin
         for (int i = (2 << d) - 1; i < BK_WORD_W; i += (2 << d)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
            pp[i] = pp[i] & pp[i - (1 << d)];
         end
      end
      for (int d = LG - 2; d >= 0; d--) begin
         for (int i = 3 * (1 << d) - 1; i < BK_WORD_W; i += (2 << d)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
            pp[i] = pp[i] & pp[i - (1 << d)];
         end
      end
      sum  = p ^ {gg[BK_WORD_W-2:0], cin};
      cout = gg[BK_WORD_W-1];
   end

endmodule

// File: rtl/bk_seq_wide_adder.sv
// WORDS x 32-bit adder, one slice per cycle; result valid WORDS cycles after accept, held until out_ready.
// in_ready low while busy; optional A-B mode when BK_SEQ_WIDE_ADDER_SUB_EN is defined (adds sub_in).
module bk_seq_wide_adder
   import bk_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BK_WORD_W*WORDS-1:0] a_in,
   input  logic [BK_WORD_W*WORDS-1:0] b_in,
   input  logic                       cin_in,
`ifdef BK_SEQ_WIDE_ADDER_SUB_EN
   input  logic                       sub_in,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BK_WORD_W*WORDS-1:0] sum_out,
   output logic                       cout_out,
   output logic                       busy
);

   localparam int W     = BK_WORD_W * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   bk_state_e      state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           carry_q, carry_d;
   logic           cout_q, cout_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic           sub_act;

   logic [BK_WORD_W-1:0] core_a;
   logic [BK_WORD_W-1:0] core_b;
   logic [BK_WORD_W-1:0] core_sum;
   logic                 core_cout;

`ifdef BK_SEQ_WIDE_ADDER_SUB_EN
   logic sub_q, sub_d;
   assign sub_act = sub_q;
`else
   assign sub_act = 1'b0;
`endif

   assign core_a = a_q[int'(idx_q)*BK_WORD_W +: BK_WORD_W];
   assign core_b = b_q[int'(idx_q)*BK_WORD_W +: BK_WORD_W] ^ {BK_WORD_W{sub_act}};

   brent_kung_adder u_core (
      .a    (core_a),
      .b    (core_b),
      .cin  (carry_q),
      .sum  (core_sum),
      .cout (core_cout)
   );

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum_out   = sum_q;
   assign cout_out  = cout_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
`ifdef BK_SEQ_WIDE_ADDER_SUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               state_d = RUN;
               a_d     = a_in;
               b_d     = b_in;
               idx_d   = '0;
`ifdef BK_SEQ_WIDE_ADDER_SUB_EN
               // subtract = A + ~B + 1, so the initial carry is forced high
               sub_d   = sub_in;
               carry_d = sub_in | cin_in;
`else
               carry_d = cin_in;
`endif
            end
         end
         RUN: begin
            sum_d[int'(idx_q)*BK_WORD_W +: BK_WORD_W] = core_sum;
            carry_d = core_cout;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               cout_d  = core_cout;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
`ifdef BK_SEQ_WIDE_ADDER_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
`ifdef BK_SEQ_WIDE_ADDER_SUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

endmodule

// File: doc/bk_seq_wide_adder.md
# bk_seq_wide_adder

Multi-cycle wide-operand adder wrapped around the existing 32-bit `brent_kung_adder`. It accepts two WORDS×32-bit operands plus carry-in on a valid/ready handshake. It adds them one 32-bit slice per cycle, least significant first, chaining the carry through a register. The result is presented on a valid/ready output port. It sits directly upstream of the combinational adder core, sequencing its `a`/`b`/`cin` inputs and consuming its `sum`/`cout`.

## Interface
- `WORDS`, 4, number of 32-bit slices; legal range 2..16; operand width is 32×WORDS.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept operands.
- `a_in`  in  32×WORDS  operand A.
- `b_in`  in  32×WORDS  operand B.
- `cin_in`  in  1  carry into slice 0.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `sum_out`  out  32×WORDS  result, registered.
- `cout_out`  out  1  carry out of the top slice, registered.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE after slice WORDS-1 completes.
  - DONE → IDLE on `out_ready`.
- On accept:
  - Latch `a_in`, `b_in` into operand registers.
  - Carry register ← `cin_in`.
  - Slice index ← 0.
- Each RUN cycle, the core sees slice[idx] of A and B plus the carry register:
  - `sum_out` slice[idx] ← core `sum`.
  - Carry register ← core `cout`.
  - idx ← idx+1.
- Entering DONE: `cout_out` ← final carry; `out_valid` goes high.
- Arithmetic is modulo 2^(32×WORDS). Overflow is reported only through `cout_out`; there is no saturation.
- Input changes while in RUN or DONE are ignored, since operands are latched.
- `in_valid` while not IDLE: no accept, no error. The request stays pending until `in_ready`.
- `out_ready` asserted outside DONE: ignored.
- Slice index is `$clog2(WORDS)` bits wide. It never wraps mid-operation and is cleared on accept.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid`=0, `busy`=0, `sum_out`=0, `cout_out`=0.
  - Carry register and idx = 0.
- `in_ready` = (state==IDLE) && !rst. It is low in any cycle `rst` is high and high the first cycle after reset release.
- Latency: accept at edge T; RUN occupies cycles T..T+WORDS-1; `out_valid` is high from cycle T+WORDS.
- `out_valid`, `sum_out` and `cout_out` hold stable until the handshake edge. `out_valid` drops the cycle after `out_valid && out_ready`.
- Next accept is possible the cycle after leaving DONE. Minimum spacing is WORDS+1 cycles with `out_ready` held high.
- `sum_out` slices update progressively during RUN. They are only valid when `out_valid`=1.
- Reset mid-operation aborts the operation: `rst` in RUN or DONE returns to IDLE next edge with all reset values and no output handshake.

## Configuration
- Macro: `BK_SEQ_WIDE_ADDER_SUB_EN`.
- Defined:
  - Adds input port `sub_in` (1 bit), sampled on accept.
  - When `sub_in`=1, B slices are inverted before the core and the carry register initialises to 1, ignoring `cin_in`. The result is A−B.
  - `cout_out`=1 means no borrow.
- Undefined: `sub_in` port absent; the block is add-only.

## Structure
- Shared package `bk_pkg`:
  - `BK_WORD_W` = 32.
  - State enum type (IDLE, RUN, DONE).
- One sub-module: the existing `brent_kung_adder`, instantiated once with ports a, b, cin, sum, cout. No other hierarchy.

## Test plan
- Reset, then idle: `in_ready`=1 cycle after release, all outputs 0.
- WORDS=4, A=0x0000…0001, B=0xFFFF…FFFF, cin=0 → sum=0 and cout=1 at accept+4 cycles; confirms carry ripples through all four slices.
- A=0x0123456789ABCDEF_FEDCBA9876543210, B=0x1111…1111, cin=1 → sum=A+B+1 (golden model); `out_ready` held low for 5 cycles; outputs held stable throughout.
- Back-to-back: 16 random pairs with `in_valid` held high and `out_ready`=1 → each result matches the model; spacing is exactly WORDS+1 cycles.
- `rst` pulsed at RUN idx=2 → IDLE next cycle, no `out_valid`, next operation correct.
- With `BK_SEQ_WIDE_ADDER_SUB_EN`: A=5, B=7, `sub_in`=1 → sum=all-ones−1 (−2), cout=0; then A=7, B=5 → sum=2, cout=1.
